// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: grants one of NUM_REQ requesters per cycle onto a registered write port.
// Define RR_ARB_EN for round-robin arbitration; otherwise the lowest valid index wins.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [5*NUM_REQ-1:0]      req_rd,
  input  logic [DATA_W*NUM_REQ-1:0] req_wd,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_hold,
  output logic                      rf_we,
  output logic [4:0]                rf_rd,
  output logic [DATA_W-1:0]         rf_wd,
  output logic [1:0]                grant_id,
  output logic [CNT_W-1:0]          conflict_cnt
);

  logic              found;
  logic [1:0]        win_idx;
  logic [4:0]        win_rd;
  logic [DATA_W-1:0] win_wd;
  logic              hs;
  logic [2:0]        nvalid;
  logic              multi;

`ifdef RR_ARB_EN
  logic [1:0] ptr;
  logic [2:0] cand;

  // Walk candidates pointer+1 .. pointer+NUM_REQ (mod NUM_REQ); first valid one wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_rd  = '0;
    win_wd  = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(NUM_REQ))
        cand = cand - 3'(NUM_REQ);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && cand == 3'(i)) begin
          found   = 1'b1;
          win_idx = 2'(i);
          win_rd  = req_rd[5*i +: 5];
          win_wd  = req_wd[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 2'(NUM_REQ - 1);
    else if (hs)
      ptr <= win_idx;
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_rd  = '0;
    win_wd  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found   = 1'b1;
        win_idx = 2'(i);
        win_rd  = req_rd[5*i +: 5];
        win_wd  = req_wd[DATA_W*i +: DATA_W];
      end
    end
  end
`endif

  assign hs = found && !wb_hold && !rst;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      req_ready[i] = hs && (win_idx == 2'(i));
  end

  always_comb begin
    nvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      nvalid = nvalid + 3'(req_valid[i]);
  end

  assign multi = (nvalid >= 3'd2);

  // x0 writes complete the handshake and update grant_id but never reach the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_rd        <= '0;
      rf_wd        <= '0;
      grant_id     <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we <= hs && (win_rd != 5'd0);
      if (hs) begin
        grant_id <= win_idx;
        if (win_rd != 5'd0) begin
          rf_rd <= win_rd;
          rf_wd <= win_wd;
        end
      end
      if (multi && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter (both arbitration builds, selected by RR_ARB_EN).
module tb_regfile_wb_arbiter;

  localparam int N   = 2;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [5*N-1:0]    req_rd;
  logic [DW*N-1:0]   req_wd;
  logic [N-1:0]      req_ready;
  logic              wb_hold;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [DW-1:0]     rf_wd;
  logic [1:0]        grant_id;
  logic [CW-1:0]     conflict_cnt;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd),
    .req_ready(req_ready), .wb_hold(wb_hold), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_wd(rf_wd), .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] wd;
    logic [1:0]    gid;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  // Requester state and reference model
  logic          rv  [N];
  logic [4:0]    rrd [N];
  logic [DW-1:0] rwd [N];
  int            mode;   // 0: go idle after grant, 1: re-issue same request, 2: random new request
  int            mptr;
  int            mcnt;
  logic          mwe;
  logic [4:0]    mrd;
  logic [DW-1:0] mwd;
  logic [1:0]    mgid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got write rd=%0d, expected no write", rf_rd);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rd", 64'(rf_rd), 64'(mon_e.rd));
        chk("sb_wd", rf_wd, mon_e.wd);
        chk("sb_gid", 64'(grant_id), 64'(mon_e.gid));
      end
    end
  end

  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef RR_ARB_EN
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic new_req(input int i);
    rv[i]  = ($urandom % 4) != 0;
    rrd[i] = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    rwd[i] = {$urandom, $urandom};
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rv[i];
      req_rd[5*i +: 5]      = rrd[i];
      req_wd[DW*i +: DW]    = rwd[i];
    end
  endtask

  task automatic model_reset();
    mptr = N - 1;
    mcnt = 0;
    mwe  = 1'b0;
    mrd  = '0;
    mwd  = '0;
    mgid = '0;
    sb.delete();
  endtask

  task automatic step(input logic hold);
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    int w, nv;
    @(negedge clk);
    if (mode == 2)
      for (int i = 0; i < N; i++)
        if (!rv[i]) new_req(i);
    drive();
    wb_hold = hold;
    nv = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = rv[i];
      nv += rv[i] ? 1 : 0;
    end
    #1;
    w = hold ? -1 : pick(v, mptr);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    if (nv >= 2 && mcnt < CNT_MAX) mcnt++;
    mwe = 1'b0;
    if (w >= 0) begin
      mgid = 2'(w);
      mptr = w;
      if (rrd[w] != 5'd0) begin
        mwe = 1'b1;
        mrd = rrd[w];
        mwd = rwd[w];
        sb.push_back('{rd: rrd[w], wd: rwd[w], gid: 2'(w)});
      end
      if (mode == 0) rv[w] = 1'b0;
      else if (mode == 2) new_req(w);
    end
    chk("rf_we", 64'(rf_we), 64'(mwe));
    chk("rf_rd", 64'(rf_rd), 64'(mrd));
    chk("rf_wd", rf_wd, mwd);
    chk("grant_id", 64'(grant_id), 64'(mgid));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(mcnt));
  endtask

  task automatic full_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    drive();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mode = 0;
    wb_hold = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b1; rrd[i] = 5'(i + 1); rwd[i] = 64'(i);
    end
    drive();
    model_reset();
    #12;
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_rd", 64'(rf_rd), 64'd0);
    chk("reset_wd", rf_wd, 64'd0);
    chk("reset_gid", 64'(grant_id), 64'd0);
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;

    // Single write
    rv[0] = 1'b1; rrd[0] = 5'd5; rwd[0] = 64'hDEAD;
    step(1'b0);
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_rd", 64'(rf_rd), 64'd5);
    chk("single_wd", rf_wd, 64'hDEAD);
    chk("single_gid", 64'(grant_id), 64'd0);

    // x0 squash
    rv[1] = 1'b1; rrd[1] = 5'd0; rwd[1] = 64'h1234;
    step(1'b0);
    chk("squash_we", 64'(rf_we), 64'd0);
    chk("squash_rd", 64'(rf_rd), 64'd5);
    chk("squash_wd", rf_wd, 64'hDEAD);
    chk("squash_gid", 64'(grant_id), 64'd1);
    step(1'b0);

    // Contention with persistent requests
    mode = 1;
    rv[0] = 1'b1; rrd[0] = 5'd3; rwd[0] = 64'hA0A0;
    rv[1] = 1'b1; rrd[1] = 5'd7; rwd[1] = 64'hB1B1;
    repeat (3) step(1'b0);
    chk("contention_cnt", 64'(conflict_cnt), 64'd3);

    // Hold during continuous valid
    step(1'b1);
    chk("hold_we", 64'(rf_we), 64'd0);
    step(1'b0);
    step(1'b0);

    // Asynchronous reset while a write is on the port
    rv[1] = 1'b0; rrd[0] = 5'd9; rwd[0] = 64'hBEEF;
    step(1'b0);
    chk("pre_reset_we", 64'(rf_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_we", 64'(rf_we), 64'd0);
    chk("async_rd", 64'(rf_rd), 64'd0);
    chk("async_wd", rf_wd, 64'd0);
    chk("async_gid", 64'(grant_id), 64'd0);
    chk("async_cnt", 64'(conflict_cnt), 64'd0);
    chk("async_ready", 64'(req_ready), 64'd0);
    model_reset();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    mode = 2;
    for (int c = 0; c < 400; c++)
      step(($urandom % 5) == 0);

    // Counter saturation
    mode = 1;
    full_reset();
    rv[0] = 1'b1; rrd[0] = 5'd3; rwd[0] = 64'h1111;
    rv[1] = 1'b1; rrd[1] = 5'd7; rwd[1] = 64'h2222;
    repeat (20) step(($urandom % 4) == 0);
    chk("saturate_cnt", 64'(conflict_cnt), 64'(CNT_MAX));

    // Drain
    mode = 0;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/rd/wd) among NUM_REQ write-back requesters, e.g. ALU, load unit and multiplier.
- Each requester uses a valid/ready handshake. One winner is accepted per cycle and registered onto the write port.
- Writes to x0 are squashed here, so the register file never sees we=1 with rd=0.
- Also reports per-cycle grant information and a saturating contention counter for performance debug.

Parameters:
- NUM_REQ, 2, number of write-back requesters (legal 2..4).
- DATA_W, 64, write data width.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request valid.
- req_rd  input  5*NUM_REQ  destination register per requester; requester i uses bits [5i+4:5i].
- req_wd  input  DATA_W*NUM_REQ  write data per requester; requester i uses slice i.
- req_ready  output  NUM_REQ  combinational grant; handshake when req_valid[i] && req_ready[i].
- wb_hold  input  1  when high, no requester is granted this cycle.
- rf_we  output  1  registered write enable to the register file.
- rf_rd  output  5  registered destination register.
- rf_wd  output  DATA_W  registered write data.
- grant_id  output  2  registered index of the requester written this cycle; valid only when rf_we=1.
- conflict_cnt  output  CNT_W  saturating count of cycles with two or more valid requests.

Behaviour:
- Reset (async assert, sync-free release): rf_we=0, rf_rd=0, rf_wd=0, grant_id=0, conflict_cnt=0, round-robin pointer=NUM_REQ-1.
- req_ready is combinational from req_valid, wb_hold and the pointer.
  - At most one bit is high.
  - All bits are 0 when wb_hold=1, when no request is valid, or during reset.
- A requester must hold req_valid, req_rd and req_wd stable until its handshake; the arbiter does not enforce this.
- Arbitration without RR_ARB_EN: fixed priority; the lowest valid index wins.
- Latency: handshake at rising edge t puts rf_we/rf_rd/rf_wd/grant_id on the outputs during cycle t..t+1. The register file commits at edge t+1. One-cycle latency, throughput of one write per cycle.
- Cycle with no handshake: next-cycle rf_we=0. rf_rd, rf_wd and grant_id hold their previous values.
- x0 squash: a granted request with rd=0 completes its handshake normally (ready=1). Next-cycle rf_we=0, and rf_rd/rf_wd are not updated. grant_id is still updated.
- Same rd from several requesters in one cycle: only the winner is written. Losers stay pending and write in later cycles, so the last granted value persists.
- conflict_cnt increments on every clock edge where popcount(req_valid) >= 2, whether or not wb_hold is set. It saturates at all-ones and does not wrap.
- wb_hold asserted mid-stream: in-flight output completes. The following cycle has rf_we=0. Pending requests wait, and the pointer is unchanged.
- Reset mid-operation: a pending write is dropped and rf_we goes low immediately, asynchronously.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: round-robin arbitration.
  - Search starts at pointer+1 modulo NUM_REQ. The first valid index wins.
  - The pointer updates to the winner index only on a handshake.
  - Guarantees no requester waits more than NUM_REQ-1 grants.
- Not defined: fixed priority (lowest index wins). The pointer register is not implemented.
- Ports and latency are identical in both builds.

Test Plan:
- Single write: req_valid=01, rd0=5, wd0=0xDEAD -> req_ready=01. Next cycle rf_we=1, rf_rd=5, rf_wd=0xDEAD, grant_id=0.
- x0 squash: req_valid=10, rd1=0, wd1=0x1234 -> req_ready=10. Next cycle rf_we=0, rf_rd/rf_wd unchanged, grant_id=1.
- Contention, fixed priority (no RR_ARB_EN): both valid for 3 cycles with rd0=3, rd1=7 -> grants 0,0,0, requester 1 never ready, conflict_cnt=3.
- Contention, RR_ARB_EN: both valid continuously after reset -> grant sequence 0,1,0,1; requester 0 rd=3 and requester 1 rd=7 alternate on rf_rd.
- wb_hold: assert during continuous valid -> req_ready=00, next cycle rf_we=0, pointer unchanged. Release -> the same requester that would have won is granted.
- Reset mid-stream and saturation: assert rst while rf_we=1 -> all outputs go to 0 asynchronously. With CNT_W=4, hold two valid requests for 20 cycles -> conflict_cnt=15.
